// File: rtl/wave_generator.sv
// Multi-mode waveform source: triangle, saw up/down, square between programmable lo/hi bounds with programmable step.
// Latency: one clk from an enabled cycle or accepted cfg_load to the new sample on out.
// Backpressure: none; ena low freezes phase/dir/out and suppresses strobes, cfg_load wins over ena.
module wave_generator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         cfg_load,
  input  logic [1:0]   mode,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] step,
  output logic [N-1:0] out,
  output logic         dir,
  output logic         period_pulse,
  output logic         cfg_err
);

  typedef enum logic [1:0] {
    TRIANGLE = 2'd0,
    SAW_UP   = 2'd1,
    SAW_DOWN = 2'd2,
    SQUARE   = 2'd3
  } mode_t;

  // Active configuration
  mode_t        mode_q, mode_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] step_q, step_d;

  // Waveform state and registered outputs
  logic [N-1:0] phase_q, phase_d;
  logic         dir_q, dir_d;
  logic [N-1:0] out_q, out_d;
  logic         pp_q, pp_d;
  logic         err_q, err_d;

  // Bound-clamped neighbours of the current phase; N+1 bits so over/underflow is visible
  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] up_next;
  logic [N-1:0] dn_next;

  // Clamp phase+step to hi and phase-step to lo; never wrap through the bounds
  always_comb begin
    sum     = {1'b0, phase_q} + {1'b0, step_q};
    diff    = {1'b0, phase_q} - {1'b0, step_q};
    up_next = (sum > {1'b0, hi_q}) ? hi_q : sum[N-1:0];
    dn_next = (diff[N] || (diff[N-1:0] < lo_q)) ? lo_q : diff[N-1:0];
  end

  // Next-state: cfg_load beats ena beats hold; out is derived from the next state so it is registered
  always_comb begin
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    step_d  = step_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    pp_d    = 1'b0;
    err_d   = 1'b0;

    if (cfg_load) begin
      if ((step == '0) || (lo > hi)) begin
        // Rejected load leaves everything as it was, including the sample
        err_d = 1'b1;
      end else begin
        mode_d = mode_t'(mode);
        lo_d   = lo;
        hi_d   = hi;
        step_d = step;
        if (mode_t'(mode) == SAW_DOWN) begin
          phase_d = hi;
          dir_d   = 1'b0;
        end else begin
          phase_d = lo;
          dir_d   = 1'b1;
        end
      end
    end else if (ena) begin
      case (mode_q)
        SAW_UP: begin
          dir_d = 1'b1;
          if (phase_q == hi_q) begin
            phase_d = lo_q;
            pp_d    = 1'b1;
          end else begin
            phase_d = up_next;
          end
        end
        SAW_DOWN: begin
          dir_d = 1'b0;
          if (phase_q == lo_q) begin
            phase_d = hi_q;
            pp_d    = 1'b1;
          end else begin
            phase_d = dn_next;
          end
        end
        default: begin
          // TRIANGLE and SQUARE share the same phase walk; direction flips on reaching a bound
          if (dir_q) begin
            phase_d = up_next;
            if (up_next == hi_q) dir_d = 1'b0;
          end else begin
            phase_d = dn_next;
            if (dn_next == lo_q) begin
              dir_d = 1'b1;
              pp_d  = 1'b1;
            end
          end
        end
      endcase
    end

    out_d = (mode_d == SQUARE) ? (dir_d ? hi_d : lo_d) : phase_d;
  end

  // State register; reset restores the legacy full-range triangle configuration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= TRIANGLE;
      lo_q    <= '0;
      hi_q    <= '1;
      step_q  <= {{(N-1){1'b0}}, 1'b1};
      phase_q <= '0;
      dir_q   <= 1'b1;
      out_q   <= '0;
      pp_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      pp_q    <= pp_d;
      err_q   <= err_d;
    end
  end

  assign out          = out_q;
  assign dir          = dir_q;
  assign period_pulse = pp_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_wave_generator.sv
// Scoreboard bench for wave_generator: the driver queues hand-computed expected samples,
// a separate monitor pops and compares one entry after each rising edge.
// Async reset is checked directly between edges.
module tb_wave_generator;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         cfg_load;
  logic [1:0]   mode;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic [N-1:0] step;
  logic [N-1:0] out;
  logic         dir;
  logic         period_pulse;
  logic         cfg_err;

  int total = 0;
  int bad   = 0;

  logic [N+2:0] exp_q[$];
  string        name_q[$];

  wave_generator #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .cfg_load     (cfg_load),
    .mode         (mode),
    .lo           (lo),
    .hi           (hi),
    .step         (step),
    .out          (out),
    .dir          (dir),
    .period_pulse (period_pulse),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge and queue the sample expected after the next rising edge
  task automatic drive(input logic e, input logic ld, input logic [1:0] m,
                       input logic [N-1:0] l, input logic [N-1:0] h, input logic [N-1:0] s,
                       input logic [N-1:0] eo, input logic ed, input logic ep, input logic ee,
                       input string nm);
    @(negedge clk);
    ena      = e;
    cfg_load = ld;
    mode     = m;
    lo       = l;
    hi       = h;
    step     = s;
    exp_q.push_back({eo, ed, ep, ee});
    name_q.push_back(nm);
  endtask

  task automatic en(input logic [N-1:0] eo, input logic ed, input logic ep, input string nm);
    drive(1'b1, 1'b0, 2'd0, '0, '0, '0, eo, ed, ep, 1'b0, nm);
  endtask

  task automatic hold(input logic [N-1:0] eo, input logic ed, input string nm);
    drive(1'b0, 1'b0, 2'd0, '0, '0, '0, eo, ed, 1'b0, 1'b0, nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: one comparison per queued expectation, sampled 1ns after the rising edge
  logic [N+2:0] mon_e;
  string        mon_nm;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        total++;
        if ({out, dir, period_pulse, cfg_err} !== mon_e) begin
          bad++;
          $display("FAIL %s: got out=%0d dir=%0b pp=%0b err=%0b, required out=%0d dir=%0b pp=%0b err=%0b",
                   mon_nm, out, dir, period_pulse, cfg_err,
                   mon_e[N+2:3], mon_e[2], mon_e[1], mon_e[0]);
        end
      end
    end
  end

  initial begin
    rst      = 1'b0;
    ena      = 1'b0;
    cfg_load = 1'b0;
    mode     = 2'd0;
    lo       = '0;
    hi       = '0;
    step     = '0;

    // Reset defaults
    #12;
    chk("reset_out", 32'(out), 0);
    chk("reset_dir", 32'(dir), 1);
    chk("reset_pp",  32'(period_pulse), 0);
    chk("reset_err", 32'(cfg_err), 0);
    @(negedge clk);
    rst = 1'b1;

    // Legacy full-range triangle: single peak at 255, single trough at 0
    for (int i = 1; i <= 255; i++) en(8'(i), (i != 255), 1'b0, "legacy_up");
    for (int i = 254; i >= 0; i--) en(8'(i), (i == 0), (i == 0), "legacy_down");
    en(8'd1, 1'b1, 1'b0, "legacy_rewrap");

    // Triangle 10..20 step 4; load with ena high takes no step
    drive(1'b1, 1'b1, 2'd0, 8'd10, 8'd20, 8'd4, 8'd10, 1'b1, 1'b0, 1'b0, "tri_load");
    en(8'd14, 1'b1, 1'b0, "tri_14");
    en(8'd18, 1'b1, 1'b0, "tri_18");
    en(8'd20, 1'b0, 1'b0, "tri_peak");
    en(8'd16, 1'b0, 1'b0, "tri_16");
    en(8'd12, 1'b0, 1'b0, "tri_12");
    en(8'd10, 1'b1, 1'b1, "tri_trough");
    en(8'd14, 1'b1, 1'b0, "tri_again");

    // Saw up 0..9 step 3
    drive(1'b1, 1'b1, 2'd1, 8'd0, 8'd9, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0, "sawup_load");
    en(8'd3, 1'b1, 1'b0, "sawup_3");
    en(8'd6, 1'b1, 1'b0, "sawup_6");
    en(8'd9, 1'b1, 1'b0, "sawup_9");
    en(8'd0, 1'b1, 1'b1, "sawup_wrap");
    en(8'd3, 1'b1, 1'b0, "sawup_3b");

    // Saw down 0..9 step 3
    drive(1'b1, 1'b1, 2'd2, 8'd0, 8'd9, 8'd3, 8'd9, 1'b0, 1'b0, 1'b0, "sawdn_load");
    en(8'd6, 1'b0, 1'b0, "sawdn_6");
    en(8'd3, 1'b0, 1'b0, "sawdn_3");
    en(8'd0, 1'b0, 1'b0, "sawdn_0");
    en(8'd9, 1'b0, 1'b1, "sawdn_wrap");

    // Square 5/200 step 100, with a 3-cycle ena gap mid-period
    drive(1'b1, 1'b1, 2'd3, 8'd5, 8'd200, 8'd100, 8'd200, 1'b1, 1'b0, 1'b0, "sq_load");
    en(8'd200, 1'b1, 1'b0, "sq_hi1");
    en(8'd5,   1'b0, 1'b0, "sq_lo0");
    en(8'd5,   1'b0, 1'b0, "sq_lo1");
    en(8'd200, 1'b1, 1'b1, "sq_period");
    en(8'd200, 1'b1, 1'b0, "sq_hi_mid");
    hold(8'd200, 1'b1, "sq_hold0");
    hold(8'd200, 1'b1, "sq_hold1");
    hold(8'd200, 1'b1, "sq_hold2");
    en(8'd5,   1'b0, 1'b0, "sq_resume_lo0");
    en(8'd5,   1'b0, 1'b0, "sq_resume_lo1");
    en(8'd200, 1'b1, 1'b1, "sq_period2");

    // Rejected loads: step==0, then lo>hi; square keeps running from where it was
    drive(1'b0, 1'b1, 2'd0, 8'd0, 8'd255, 8'd0, 8'd200, 1'b1, 1'b0, 1'b1, "rej_step0");
    en(8'd200, 1'b1, 1'b0, "rej_after1");
    drive(1'b0, 1'b1, 2'd0, 8'd50, 8'd40, 8'd1, 8'd200, 1'b1, 1'b0, 1'b1, "rej_lo_gt_hi");
    en(8'd5,   1'b0, 1'b0, "rej_after2");
    en(8'd5,   1'b0, 1'b0, "rej_after3");
    en(8'd200, 1'b1, 1'b1, "rej_after_period");

    // Degenerate lo==hi triangle: out constant, dir toggles, pulse on each return to lo
    drive(1'b1, 1'b1, 2'd0, 8'd7, 8'd7, 8'd1, 8'd7, 1'b1, 1'b0, 1'b0, "eq_load");
    en(8'd7, 1'b0, 1'b0, "eq_down");
    en(8'd7, 1'b1, 1'b1, "eq_up_pulse");
    en(8'd7, 1'b0, 1'b0, "eq_down2");

    // Mid-ramp async reset reverts to the default step=1 triangle
    drive(1'b1, 1'b1, 2'd0, 8'd0, 8'd100, 8'd5, 8'd0, 1'b1, 1'b0, 1'b0, "rr_load");
    en(8'd5,  1'b1, 1'b0, "rr_5");
    en(8'd10, 1'b1, 1'b0, "rr_10");
    en(8'd15, 1'b1, 1'b0, "rr_15");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 0);
    chk("async_rst_dir", 32'(dir), 1);
    chk("async_rst_pp",  32'(period_pulse), 0);
    en(8'd0, 1'b1, 1'b0, "in_rst0");
    en(8'd0, 1'b1, 1'b0, "in_rst1");
    @(negedge clk);
    rst = 1'b1;
    ena = 1'b0;
    en(8'd1, 1'b1, 1'b0, "post_rst_1");
    en(8'd2, 1'b1, 1'b0, "post_rst_2");
    en(8'd3, 1'b1, 1'b0, "post_rst_3");

    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_generator.md
Name: wave_generator

Overview:
- Parametrised multi-mode waveform source, successor to the fixed 0..2^N-1 up/down counter.
- Produces triangle, rising sawtooth, falling sawtooth or square waveforms between runtime-programmable bounds, with a programmable step.
- Advances only on enabled cycles.
- Sits between control registers and the PWM/DAC datapath; emits a per-period strobe for downstream sequencing.

Parameters:
- N, 8, sample/output width in bits; also width of lo, hi, step.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately when low, releases synchronously to clk.
- ena  input  1  advance enable; when low, all state holds.
- cfg_load  input  1  single-cycle strobe; samples mode/lo/hi/step into the active configuration.
- mode  input  2  0=TRIANGLE, 1=SAW_UP, 2=SAW_DOWN, 3=SQUARE.
- lo  input  N  lower bound, inclusive.
- hi  input  N  upper bound, inclusive.
- step  input  N  increment per enabled cycle.
- out  output  N  current sample.
- dir  output  1  1=counting up, 0=counting down (internal phase direction).
- period_pulse  output  1  one-cycle strobe at end of each waveform period.
- cfg_err  output  1  one-cycle strobe when a cfg_load is rejected.

Behaviour:
- Reset (rst low):
  - Active config: mode=TRIANGLE, lo=0, hi=2^N-1, step=1.
  - Internal phase=0, out=0, dir=1, period_pulse=0, cfg_err=0.
  - This configuration reproduces the legacy triangle sequence exactly.
- State: registered active config (mode, lo, hi, step), phase[N-1:0], dir. No combinational paths from inputs to outputs; every output is registered.
- Priority per cycle: cfg_load > ena > hold.
- cfg_load:
  - Rejected if step==0 or lo>hi. On reject: cfg_err=1 next cycle; config, phase, dir and out are unchanged.
  - Otherwise config is replaced. For SAW_DOWN: phase=hi, dir=0. For all other modes: phase=lo, dir=1.
  - A load with lo==hi is legal; out then stays constant at lo.
  - No step is taken on a load cycle, even if ena=1.
- Arithmetic: compute phase+step and phase-step in N+1 bits. Clamp with up_next = min(phase+step, hi) and dn_next = max(phase-step, lo). No wrap past the bounds, ever.
- On an enabled cycle (ena=1, cfg_load=0):
  - TRIANGLE, dir=1: phase<=up_next; if up_next==hi then dir<=0.
  - TRIANGLE, dir=0: phase<=dn_next; if dn_next==lo then dir<=1 and period_pulse<=1.
  - Each endpoint is held for exactly one enabled sample (no double peak).
  - SAW_UP: if phase==hi then phase<=lo and period_pulse<=1; else phase<=up_next. dir stays 1.
  - SAW_DOWN: if phase==lo then phase<=hi and period_pulse<=1; else phase<=dn_next. dir stays 0.
  - SQUARE: phase and dir evolve exactly as TRIANGLE (including period_pulse). out = hi while dir=1, lo while dir=0.
- out for TRIANGLE and SAW modes equals phase.
- period_pulse and cfg_err are high for exactly one clk cycle, then return to 0. They are never asserted on a held cycle.
- lo==hi in TRIANGLE/SQUARE: each enabled cycle toggles dir and pulses period_pulse on every return to lo. out stays at lo.
- ena=0: phase, dir and out hold; pulse outputs are 0.
- Mid-operation reset: outputs go to reset values asynchronously and the active config reverts to the defaults.
- Latency: an enabled cycle or accepted load is visible on out at the following clk edge (1 cycle).

Test Plan:
- Reset defaults, ena=1 continuous, N=8 -> out 0,1,...,255,254,...,0,1. period_pulse high exactly in the cycle out returns to 0. No repeated 255 or 0.
- Load TRIANGLE lo=10 hi=20 step=4 -> out 10,14,18,20,16,12,10,14. dir falls at 20. period_pulse at the second 10.
- Load SAW_UP lo=0 hi=9 step=3 -> out 0,3,6,9,0,3 with period_pulse in the wrap cycle. Then SAW_DOWN same bounds -> out 9,6,3,0,9.
- Load SQUARE lo=5 hi=200 step=100 -> out 200,200,5,5 repeating, with period_pulse each period. Toggle ena low for 3 cycles mid-period -> out/dir frozen, no pulse.
- Load with step=0, then with lo=50 hi=40 -> cfg_err pulses once each; waveform continues uninterrupted. Assert cfg_load and ena together -> no step on that cycle.
- Drop rst asynchronously mid-ramp (between edges) -> out=0 immediately. After release, legacy triangle resumes from 0.
